pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Frame-rate game controller for the Pong display path. It sequences one update of paddle positions, ball position, collisions and score per video frame, and owns the play state machine. It sits between the `vga_sync` timing generator, which supplies the frame tick, and the pixel renderer, which reads its position and score outputs. All outputs change only during vertical blank, so the renderer always sees a stable scene within a frame.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible width in pixels.
- `V_ACTIVE`, 480: visible height in lines.
- `BALL_SIZE`, 8: ball edge length, in pixels.
- `PAD_W`, 8: paddle width, in pixels.
- `PAD_H`, 64: paddle height, in pixels.
- `PAD_L_X`, 16: left paddle left edge.
- `PAD_R_X`, 616: right paddle left edge.
- `BALL_SPEED`, 2: ball step per frame on each axis.
- `PAD_SPEED`, 4: paddle step per frame.
- `WIN_SCORE`, 9: score that ends the game.
- `PAUSE_FRAMES`, 60: frames the ball is held after a point.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blank.
- `serve` in 1: one-cycle pulse that starts play or restarts after game over.
- `up_l`, `dn_l`, `up_r`, `dn_r` in 1 each: paddle controls, already debounced and level.
- `ball_x` out 10: ball left edge.
- `ball_y` out 10: ball top edge.
- `pad_l_y`, `pad_r_y` out 10 each: paddle top edges.
- `score_l`, `score_r` out 4 each: player scores.
- `game_state` out 2: 0 = IDLE, 1 = PLAY, 2 = POINT, 3 = OVER.
- `busy` out 1: update sequence in progress.

## Operation
- State machine:
  - IDLE + `serve` -> PLAY; ball direction dx=+, dy=+.
  - PLAY + point scored -> POINT, or -> OVER if the scorer reaches `WIN_SCORE`.
  - POINT: pause counter counts frames; after `PAUSE_FRAMES` ticks -> PLAY, with dx pointing toward the player who conceded the point.
  - OVER + `serve` -> IDLE; both scores cleared; ball centred.
  - `serve` in PLAY or POINT is ignored.
- Paddles update every frame in all states except OVER.
  - Up only: subtract `PAD_SPEED`, saturating at 0.
  - Down only: add `PAD_SPEED`, saturating at `V_ACTIVE-PAD_H` (416).
  - Both pressed or neither: hold position.
- Ball moves only in PLAY. In IDLE, POINT and OVER it is held at centre (316, 236).
- Ball arithmetic:
  - Compute next positions in 11-bit signed form: next = pos ± `BALL_SPEED`.
  - Vertical: next_y <= 0 -> y=0, dy=+. next_y >= 472 -> y=472, dy=-.
  - Left paddle hit: dx=- and next_x <= 24 and vertical overlap (ball_y+8 > pad_l_y and ball_y < pad_l_y+64) -> x=24, dx=+.
  - Right paddle hit: dx=+ and next_x+8 >= 616 with overlap on the right paddle -> x=608, dx=-.
  - Miss: next_x <= 0 scores for the right player; next_x >= 632 scores for the left player. The ball recentres.
- Paddle overlap tests use the paddle positions as updated in the same frame.
- Scores saturate at `WIN_SCORE`.

## Timing
- `frame_tick` asserted in cycle T:
  - Edge T+1: paddle registers update; `busy`=1.
  - Edge T+2: ball, direction, score, `game_state` and pause counter update; `busy` drops to 0 at T+3.
- `frame_tick` arriving while `busy`=1 is ignored.
- `serve` acts on the next edge, independent of `frame_tick`.
- Reset values:
  - `ball_x`=316, `ball_y`=236.
  - `pad_l_y` = `pad_r_y` = 208.
  - Scores 0; dx=+, dy=+; pause counter 0.
  - `game_state`=IDLE; `busy`=0.
- `rst` asserted during an update sequence aborts it; all reset values hold on the following edge.
- Simultaneous hits:
  - Wall and paddle in the same frame: both directions reflect.
  - Corner hit at y=0 together with a paddle hit: resolve both in the same update.

## Test plan
- Reset -> all outputs at the reset values; `busy`=0.
- IDLE, `serve`, then 10 ticks with no buttons -> ball_x=336, ball_y=256; `game_state`=PLAY.
- Hold `up_l` for 60 ticks from 208 -> `pad_l_y` reaches 0 after 52 ticks and stays 0. Press `up_l` and `dn_l` together -> position unchanged.
- Ball at (26, 100) with dx=-, `pad_l_y`=80, one tick -> x=24, dx=+. Same setup with `pad_l_y`=300 -> ball reaches x<=0 on later ticks, `score_r` increments, `game_state`=POINT, ball returns to (316, 236).
- POINT -> exactly 60 ticks then PLAY with dx toward the player who conceded. `score_l` reaching 9 -> OVER. `serve` in OVER -> IDLE with both scores 0.
- `frame_tick` on consecutive cycles -> only one update. `rst` pulsed at T+1 -> reset state with no partial ball update.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong frame-rate game controller.
// Paddles, ball, score and play FSM, updated once per frame in vblank.
module pong_game_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 64,
  parameter int PAD_L_X      = 16,
  parameter int PAD_R_X      = 616,
  parameter int BALL_SPEED   = 2,
  parameter int PAD_SPEED    = 4,
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic       up_l,
  input  logic       dn_l,
  input  logic       up_r,
  input  logic       dn_r,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_l_y,
  output logic [9:0] pad_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] game_state,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    POINT = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [9:0] X_C   = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] Y_C   = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] P_C   = 10'((V_ACTIVE - PAD_H) / 2);
  localparam logic [9:0] P_MAX = 10'(V_ACTIVE - PAD_H);
  localparam logic [9:0] P_SPD = 10'(PAD_SPEED);

  localparam logic signed [10:0] B_SPD = 11'(BALL_SPEED);
  localparam logic signed [10:0] Y_MAX = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] L_HIT = 11'(PAD_L_X + PAD_W);
  localparam logic signed [10:0] R_HIT = 11'(PAD_R_X - BALL_SIZE);
  localparam logic signed [10:0] X_MAX = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] ZERO  = 11'sd0;

  localparam logic [10:0] B_SZ = 11'(BALL_SIZE);
  localparam logic [10:0] P_HT = 11'(PAD_H);
  localparam logic [3:0]  WIN  = 4'(WIN_SCORE);

  localparam int CW = $clog2(PAUSE_FRAMES + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PAUSE_FRAMES - 1);

  state_t          state;
  logic [1:0]      phase;
  logic            dx;
  logic            dy;
  logic            conc_l;
  logic [CW-1:0]   pause_cnt;

  logic signed [10:0] sx, sy, nx, ny;
  logic [10:0]     ey;
  logic            ovl_l, ovl_r;
  logic [9:0]      bx_n, by_n;
  logic            dx_n, dy_n;
  logic            miss, miss_r;
  logic [3:0]      sl_inc, sr_inc;

  assign game_state = state;

  function automatic logic [9:0] pad_step(
    input logic [9:0] p,
    input logic       up,
    input logic       dn
  );
    logic [9:0] r;
    r = p;
    if (up && !dn)
      r = (p < P_SPD) ? 10'd0 : p - P_SPD;
    else if (dn && !up)
      r = (p > P_MAX - P_SPD) ? P_MAX : p + P_SPD;
    return r;
  endfunction

  // Next ball position, wall and paddle reflections, miss detection.
  always_comb begin
    sx = {1'b0, ball_x};
    sy = {1'b0, ball_y};
    ey = {1'b0, ball_y};
    nx = dx ? sx + B_SPD : sx - B_SPD;
    ny = dy ? sy + B_SPD : sy - B_SPD;
    ovl_l = (ey + B_SZ > {1'b0, pad_l_y}) &&
            (ey < {1'b0, pad_l_y} + P_HT);
    ovl_r = (ey + B_SZ > {1'b0, pad_r_y}) &&
            (ey < {1'b0, pad_r_y} + P_HT);
    by_n = ny[9:0];
    dy_n = dy;
    if (ny <= ZERO) begin
      by_n = 10'd0;
      dy_n = 1'b1;
    end else if (ny >= Y_MAX) begin
      by_n = Y_MAX[9:0];
      dy_n = 1'b0;
    end
    bx_n   = nx[9:0];
    dx_n   = dx;
    miss   = 1'b0;
    miss_r = 1'b0;
    if (!dx) begin
      if (nx <= L_HIT && ovl_l) begin
        bx_n = L_HIT[9:0];
        dx_n = 1'b1;
      end else if (nx <= ZERO) begin
        miss   = 1'b1;
        miss_r = 1'b1;
      end
    end else begin
      if (nx >= R_HIT && ovl_r) begin
        bx_n = R_HIT[9:0];
        dx_n = 1'b0;
      end else if (nx >= X_MAX) begin
        miss = 1'b1;
      end
    end
    sl_inc = (score_l < WIN) ? score_l + 4'd1 : score_l;
    sr_inc = (score_r < WIN) ? score_r + 4'd1 : score_r;
  end

  // Frame sequencer: paddles, then ball/score/FSM, then release busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 2'd0;
      busy      <= 1'b0;
      dx        <= 1'b1;
      dy        <= 1'b1;
      conc_l    <= 1'b0;
      pause_cnt <= '0;
      ball_x    <= X_C;
      ball_y    <= Y_C;
      pad_l_y   <= P_C;
      pad_r_y   <= P_C;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
    end else begin
      unique case (1'b1)
        (phase == 2'd0): begin
          if (frame_tick) begin
            phase <= 2'd1;
            busy  <= 1'b1;
            if (state != OVER) begin
              pad_l_y <= pad_step(pad_l_y, up_l, dn_l);
              pad_r_y <= pad_step(pad_r_y, up_r, dn_r);
            end
          end
        end
        (phase == 2'd1): begin
          phase <= 2'd2;
          case (state)
            PLAY: begin
              if (miss) begin
                ball_x    <= X_C;
                ball_y    <= Y_C;
                pause_cnt <= '0;
                conc_l    <= miss_r;
                if (miss_r) begin
                  score_r <= sr_inc;
                  state   <= (sr_inc == WIN) ? OVER : POINT;
                end else begin
                  score_l <= sl_inc;
                  state   <= (sl_inc == WIN) ? OVER : POINT;
                end
              end else begin
                ball_x <= bx_n;
                ball_y <= by_n;
                dx     <= dx_n;
                dy     <= dy_n;
              end
            end
            POINT: begin
              if (pause_cnt == P_LAST) begin
                pause_cnt <= '0;
                state     <= PLAY;
                dx        <= !conc_l;
              end else begin
                pause_cnt <= pause_cnt + 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
        default: begin
          phase <= 2'd0;
          busy  <= 1'b0;
        end
      endcase
      if (serve) begin
        if (state == IDLE) begin
          state <= PLAY;
          dx    <= 1'b1;
          dy    <= 1'b1;
        end else if (state == OVER) begin
          state   <= IDLE;
          score_l <= 4'd0;
          score_r <= 4'd0;
          ball_x  <= X_C;
          ball_y  <= Y_C;
        end
      end
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: paddle vector table plus a
// behavioural game model feeding a per-frame scoreboard.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, frame_tick, serve;
  logic       up_l, dn_l, up_r, dn_r;
  logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0] score_l, score_r;
  logic [1:0] game_state;
  logic       busy;

  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .serve(serve),
    .up_l(up_l), .dn_l(dn_l), .up_r(up_r), .dn_r(dn_r),
    .ball_x(ball_x), .ball_y(ball_y),
    .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .score_l(score_l), .score_r(score_r),
    .game_state(game_state), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st, m_cnt;
  bit m_dx, m_dy, m_conc_l;
  logic [63:0] sb[$];

  typedef struct {
    logic [3:0] btn;
    int n;
    int el;
    int er;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(int bx, int by, int pl, int pr,
                                     int sl, int sr, int st);
    return {14'b0, 10'(bx), 10'(by), 10'(pl), 10'(pr),
            4'(sl), 4'(sr), 2'(st)};
  endfunction

  function automatic logic [63:0] dut_pk();
    return pk(int'(ball_x), int'(ball_y), int'(pad_l_y),
              int'(pad_r_y), int'(score_l), int'(score_r),
              int'(game_state));
  endfunction

  function automatic logic [63:0] m_pk();
    return pk(m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st);
  endfunction

  task automatic m_reset();
    m_bx = 316; m_by = 236; m_pl = 208; m_pr = 208;
    m_sl = 0; m_sr = 0; m_st = 0; m_cnt = 0;
    m_dx = 1; m_dy = 1; m_conc_l = 0;
  endtask

  function automatic int padm(int p, bit up, bit dn);
    if (up && !dn) return (p < 4) ? 0 : p - 4;
    if (dn && !up) return (p + 4 > 416) ? 416 : p + 4;
    return p;
  endfunction

  task automatic m_step();
    int nx, ny, oy;
    bit pt, rs;
    if (m_st != 3) begin
      m_pl = padm(m_pl, up_l, dn_l);
      m_pr = padm(m_pr, up_r, dn_r);
    end
    if (m_st == 1) begin
      oy = m_by;
      nx = m_dx ? m_bx + 2 : m_bx - 2;
      ny = m_dy ? m_by + 2 : m_by - 2;
      if (ny <= 0) begin m_by = 0; m_dy = 1; end
      else if (ny >= 472) begin m_by = 472; m_dy = 0; end
      else m_by = ny;
      pt = 0; rs = 0;
      if (!m_dx) begin
        if (nx <= 24 && oy + 8 > m_pl && oy < m_pl + 64) begin
          m_bx = 24; m_dx = 1;
        end else if (nx <= 0) begin
          pt = 1; rs = 1;
        end else m_bx = nx;
      end else begin
        if (nx + 8 >= 616 && oy + 8 > m_pr && oy < m_pr + 64) begin
          m_bx = 608; m_dx = 0;
        end else if (nx >= 632) begin
          pt = 1;
        end else m_bx = nx;
      end
      if (pt) begin
        m_bx = 316; m_by = 236; m_cnt = 0; m_conc_l = rs;
        if (rs) begin
          if (m_sr < 9) m_sr++;
          m_st = (m_sr == 9) ? 3 : 2;
        end else begin
          if (m_sl < 9) m_sl++;
          m_st = (m_sl == 9) ? 3 : 2;
        end
      end
    end else if (m_st == 2) begin
      m_cnt++;
      if (m_cnt == 60) begin
        m_st = 1; m_cnt = 0; m_dx = !m_conc_l;
      end
    end
  endtask

  task automatic tick(input int hold);
    int k;
    logic [63:0] e;
    m_step();
    sb.push_back(m_pk());
    frame_tick = 1'b1;
    @(posedge clk); #1;
    chk("busy_rise", 64'(busy), 64'd1);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
    end
    frame_tick = 1'b0;
    k = 0;
    while (busy && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) chk("busy_timeout", 64'(busy), 64'd0);
    e = sb.pop_front();
    chk("frame", dut_pk(), e);
  endtask

  task automatic do_serve();
    if (m_st == 0) begin
      m_st = 1; m_dx = 1; m_dy = 1;
    end else if (m_st == 3) begin
      m_st = 0; m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236;
    end
    serve = 1'b1;
    @(posedge clk); #1;
    serve = 1'b0;
    chk("serve", dut_pk(), m_pk());
  endtask

  task automatic track_l();
    int t;
    t = m_by - 28;
    up_l = (m_pl > t);
    dn_l = (m_pl < t);
  endtask

  task automatic track_r();
    int t;
    t = m_by - 28;
    up_r = (m_pr > t);
    dn_r = (m_pr < t);
  endtask

  initial begin
    int n, pl_hold;
    tbl[0] = '{4'b1000, 51, 4, 208};
    tbl[1] = '{4'b1000, 1, 0, 208};
    tbl[2] = '{4'b1000, 8, 0, 208};
    tbl[3] = '{4'b1100, 3, 0, 208};
    tbl[4] = '{4'b0100, 5, 20, 208};
    tbl[5] = '{4'b0001, 60, 20, 416};
    tbl[6] = '{4'b0011, 2, 20, 416};
    tbl[7] = '{4'b0010, 4, 20, 400};
    tbl[8] = '{4'b0000, 3, 20, 400};
    tbl[9] = '{4'b1010, 1, 16, 396};

    rst = 1; frame_tick = 0; serve = 0;
    up_l = 0; dn_l = 0; up_r = 0; dn_r = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", dut_pk(), pk(316, 236, 208, 208, 0, 0, 0));
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 0;
    m_reset();

    foreach (tbl[i]) begin
      {up_l, dn_l, up_r, dn_r} = tbl[i].btn;
      for (int j = 0; j < tbl[i].n; j++) tick(1);
      chk($sformatf("tbl%0d_pads", i), {pad_l_y, pad_r_y},
          {10'(tbl[i].el), 10'(tbl[i].er)});
      chk($sformatf("tbl%0d_ball", i), {ball_x, ball_y, game_state},
          {10'd316, 10'd236, 2'd0});
    end

    {up_l, dn_l, up_r, dn_r} = 4'b0000;
    do_serve();
    for (int j = 0; j < 10; j++) tick(1);
    chk("play10", {ball_x, ball_y, game_state},
        {10'd336, 10'd256, 2'd1});
    do_serve();
    chk("serve_in_play", 64'(game_state), 64'd1);
    tick(2);
    chk("double_tick", 64'(ball_x), 64'd338);

    up_l = 1;
    frame_tick = 1;
    @(posedge clk); #1;
    frame_tick = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_outs", dut_pk(), pk(316, 236, 208, 208, 0, 0, 0));
    chk("abort_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("abort_hold", dut_pk(), pk(316, 236, 208, 208, 0, 0, 0));
    m_reset();
    up_l = 0;

    do_serve();
    n = 0;
    while (m_sr == 0 && n < 3000) begin
      up_l = (m_by >= 236) ? (m_pl > 0) : 1'b0;
      dn_l = (m_by < 236) ? (m_pl < 416) : 1'b0;
      track_r();
      tick(1);
      n++;
    end
    chk("score_r_first", {score_r, game_state, ball_x, ball_y},
        {4'd1, 2'd2, 10'd316, 10'd236});
    {up_l, dn_l, up_r, dn_r} = 4'b0000;
    for (int j = 0; j < 59; j++) tick(1);
    chk("pause59", 64'(game_state), 64'd2);
    tick(1);
    chk("pause60", 64'(game_state), 64'd1);
    tick(1);
    chk("serve_dir", 64'(ball_x), 64'd314);

    n = 0;
    while (m_st != 3 && n < 8000) begin
      track_l();
      up_r = 1'($urandom_range(0, 1));
      dn_r = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    chk("game_over", {score_l, score_r, game_state},
        {4'd9, 4'd1, 2'd3});
    pl_hold = m_pl;
    up_l = 1; dn_l = 0; up_r = 0; dn_r = 1;
    tick(1);
    chk("over_pad_hold", 64'(pad_l_y), 64'(pl_hold));
    do_serve();
    chk("over_serve", {score_l, score_r, game_state, ball_x},
        {4'd0, 4'd0, 2'd0, 10'd316});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
